// File: rtl/counter_pkg.sv
// Shared constants and elaboration helpers for the modulo-N up/down counter.
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    // Ceiling log2 of value; 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = (value > 0) ? value - 1 : 0; v != 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Prescaler register width: a PRESCALE of 1 still needs a 1-bit register.
    function automatic int unsigned prescale_width(input int unsigned prescale);
        int unsigned w;
        w = clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/counter_updown_mod_if.sv
// Control/status bundle between the pin wrapper (master) and the counter (slave).
interface counter_updown_mod_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             sat_mode;
    logic [WIDTH-1:0] cmp_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             tc;
    logic             ovf;
    logic             match;

    modport master (
        output en, up, load, load_val, sat_mode, cmp_val, clr_ovf,
        input  count, tick, tc, ovf, match
    );

    modport slave (
        input  en, up, load, load_val, sat_mode, cmp_val, clr_ovf,
        output count, tick, tc, ovf, match
    );
endinterface

// File: rtl/tick_prescaler.sv
// Enable prescaler: emits one tick every PRESCALE enabled cycles; sync_clr restarts the period.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int unsigned PW = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (sync_clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// Modulo-N up/down counter with load, wrap/saturate, prescaled enable, terminal count,
// sticky overflow and compare match.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 2 ** WIDTH,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst,
    counter_updown_mod_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

    logic             tick;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             at_top;
    logic             at_bot;
    logic             end_evt;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.en),
        .sync_clr (bus.load),
        .tick     (tick)
    );

    assign at_top = (count_q == MAX_C);
    assign at_bot = (count_q == '0);

    // Next count: load beats step beats hold; range-end steps flag an overflow event.
    always_comb begin
        count_d = count_q;
        end_evt = 1'b0;
        if (bus.load) begin
            count_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
        end else if (tick) begin
            case (bus.up)
                DIR_UP: begin
                    if (at_top) begin
                        end_evt = 1'b1;
                        count_d = (bus.sat_mode == MODE_SAT) ? MAX_C : '0;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                DIR_DOWN: begin
                    if (at_bot) begin
                        end_evt = 1'b1;
                        count_d = (bus.sat_mode == MODE_WRAP) ? MAX_C : '0;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                default: count_d = count_q;
            endcase
        end
    end

    // Flags: tc is a one-cycle echo of the event; ovf set wins over clear.
    always_comb begin
        tc_d  = end_evt;
        ovf_d = ovf_q;
        if (end_evt) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tick  = tick;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;
    assign bus.match = (count_q == bus.cmp_val);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: table-driven vectors on a PRESCALE=1 instance
// plus hand sequences for reset, prescaler gating and load-on-tick on a PRESCALE=3 instance.
module tb_counter_updown_mod;

    localparam int unsigned W = 4;
    localparam int unsigned M = 10;

    typedef struct {
        logic         en;
        logic         up;
        logic         load;
        logic [W-1:0] lv;
        logic         sat;
        logic         clr;
        logic [W-1:0] cmp;
        logic [W-1:0] e_cnt;
        logic         e_tc;
        logic         e_ovf;
        logic         e_match;
    } vec_t;

    typedef struct {
        logic         en;
        logic         load;
        logic [W-1:0] lv;
        logic         e_tick;
        logic [W-1:0] e_cnt;
        logic         e_tc;
    } bvec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    vec_t  va[$];
    bvec_t vb[$];

    counter_updown_mod_if #(.WIDTH(W)) ifa ();
    counter_updown_mod_if #(.WIDTH(W)) ifb ();

    counter_updown_mod #(.WIDTH(W), .MODULUS(M), .PRESCALE(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    counter_updown_mod #(.WIDTH(W), .MODULUS(M), .PRESCALE(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic en, logic up, logic load, int lv, logic sat, logic clr,
                                int cmp, int e_cnt, logic e_tc, logic e_ovf, logic e_match);
        vec_t v;
        v.en = en; v.up = up; v.load = load; v.lv = W'(lv); v.sat = sat; v.clr = clr;
        v.cmp = W'(cmp); v.e_cnt = W'(e_cnt); v.e_tc = e_tc; v.e_ovf = e_ovf; v.e_match = e_match;
        return v;
    endfunction

    function automatic bvec_t mkb(logic en, logic load, int lv, logic e_tick, int e_cnt, logic e_tc);
        bvec_t v;
        v.en = en; v.load = load; v.lv = W'(lv); v.e_tick = e_tick; v.e_cnt = W'(e_cnt); v.e_tc = e_tc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input vec_t v);
        ifa.en = v.en; ifa.up = v.up; ifa.load = v.load; ifa.load_val = v.lv;
        ifa.sat_mode = v.sat; ifa.clr_ovf = v.clr; ifa.cmp_val = v.cmp;
    endtask

    initial begin
        logic tick_seen;
        n_tests = 0;
        n_fail  = 0;

        // Vector table for the PRESCALE=1 instance: {count,tc,ovf,match} after the edge.
        for (int i = 1; i <= 9; i++) va.push_back(mk(1, 1, 0, 0, 0, 0, 5, i, 0, 0, i == 5));
        va.push_back(mk(1, 1, 0, 0,  0, 0, 5,  0, 1, 1, 0)); // up wrap 9 -> 0
        va.push_back(mk(1, 1, 0, 0,  0, 0, 5,  1, 0, 1, 0)); // ovf sticky, tc one cycle
        va.push_back(mk(0, 1, 0, 0,  0, 0, 5,  1, 0, 1, 0)); // en=0 holds
        va.push_back(mk(1, 1, 1, 13, 0, 0, 5,  9, 0, 1, 0)); // load clamps, step suppressed
        va.push_back(mk(1, 1, 0, 0,  0, 1, 5,  0, 1, 1, 0)); // wrap + clr: set wins
        va.push_back(mk(0, 1, 0, 0,  0, 1, 5,  0, 0, 0, 0)); // clr alone
        va.push_back(mk(0, 0, 1, 2,  1, 0, 5,  2, 0, 0, 0)); // load 2
        va.push_back(mk(1, 0, 0, 0,  1, 0, 5,  1, 0, 0, 0));
        va.push_back(mk(1, 0, 0, 0,  1, 0, 5,  0, 0, 0, 0));
        va.push_back(mk(1, 0, 0, 0,  1, 0, 5,  0, 1, 1, 0)); // saturated step at 0
        va.push_back(mk(1, 0, 0, 0,  1, 0, 5,  0, 1, 1, 0)); // repeated tc
        va.push_back(mk(1, 1, 0, 0,  1, 0, 5,  1, 0, 1, 0));
        va.push_back(mk(0, 1, 1, 9,  1, 0, 5,  9, 0, 1, 0));
        va.push_back(mk(1, 1, 0, 0,  1, 0, 5,  9, 1, 1, 0)); // saturate at top
        va.push_back(mk(1, 0, 0, 0,  0, 0, 5,  8, 0, 1, 0)); // direction change mid-count
        va.push_back(mk(0, 0, 1, 0,  0, 0, 5,  0, 0, 1, 0)); // load leaves ovf alone
        va.push_back(mk(1, 0, 0, 0,  0, 0, 5,  9, 1, 1, 0)); // down wrap 0 -> 9
        va.push_back(mk(1, 0, 1, 15, 0, 0, 5,  9, 0, 1, 0)); // load on tick, clamp
        va.push_back(mk(0, 0, 1, 5,  0, 0, 5,  5, 0, 1, 1)); // match
        va.push_back(mk(0, 0, 0, 0,  0, 0, 12, 5, 0, 1, 0)); // cmp >= MODULUS never matches
        va.push_back(mk(1, 1, 0, 0,  0, 0, 5,  6, 0, 1, 0));

        // PRESCALE=3 sequence: {tick before edge, count, tc after edge}.
        for (int i = 1; i <= 9; i++) vb.push_back(mkb(1, 0, 0, (i % 3) == 0, i / 3, 0));
        vb.push_back(mkb(1, 0, 0,  0, 3, 0));  // prescaler 0 -> 1
        vb.push_back(mkb(0, 0, 0,  0, 3, 0));  // frozen
        vb.push_back(mkb(0, 0, 0,  0, 3, 0));  // frozen
        vb.push_back(mkb(1, 0, 0,  0, 3, 0));  // 1 -> 2
        vb.push_back(mkb(1, 0, 0,  1, 4, 0));  // step two cycles late
        vb.push_back(mkb(1, 0, 0,  0, 4, 0));
        vb.push_back(mkb(1, 0, 0,  0, 4, 0));
        vb.push_back(mkb(1, 1, 13, 1, 9, 0));  // load on tick: tick shown, no step
        vb.push_back(mkb(1, 0, 0,  0, 9, 0));  // prescaler restarted
        vb.push_back(mkb(1, 0, 0,  0, 9, 0));
        vb.push_back(mkb(1, 0, 0,  1, 0, 1));  // wrap with tc

        ifa.en = 0; ifa.up = 0; ifa.load = 0; ifa.load_val = '0;
        ifa.sat_mode = 0; ifa.clr_ovf = 0; ifa.cmp_val = W'(5);
        ifb.en = 0; ifb.up = 1; ifb.load = 0; ifb.load_val = '0;
        ifb.sat_mode = 0; ifb.clr_ovf = 0; ifb.cmp_val = W'(15);
        rst = 1'b1;
        #1;
        check("reset_a", {28'(ifa.count), ifa.tc, ifa.ovf, 2'b00}, 32'h0);
        check("reset_b", {28'(ifb.count), ifb.tc, ifb.ovf, 2'b00}, 32'h0);
        #11 rst = 1'b0;
        next_cycle();

        foreach (va[i]) begin
            drive_a(va[i]);
            #1;
            tick_seen = ifa.tick;
            next_cycle();
            check($sformatf("vec_a[%0d] {tick,count,tc,ovf,match}", i),
                  {27'(0), tick_seen, ifa.count, ifa.tc, ifa.ovf, ifa.match},
                  {27'(0), va[i].en, va[i].e_cnt, va[i].e_tc, va[i].e_ovf, va[i].e_match});
        end

        // Asynchronous reset between edges with count=7 and ovf set.
        drive_a(mk(0, 1, 1, 7, 0, 0, 5, 0, 0, 0, 0));
        next_cycle();
        ifa.load = 0;
        check("pre_reset_a {count,ovf}", {ifa.count, ifa.ovf}, {W'(7), 1'b1});
        #2 rst = 1'b1;
        #1;
        check("async_reset_a {count,tc,ovf}", {ifa.count, ifa.tc, ifa.ovf}, {W'(0), 1'b0, 1'b0});
        #1 rst = 1'b0;
        next_cycle();
        check("post_reset_a count", 32'(ifa.count), 32'd0);

        foreach (vb[i]) begin
            ifb.en = vb[i].en; ifb.load = vb[i].load; ifb.load_val = vb[i].lv;
            #1;
            tick_seen = ifb.tick;
            next_cycle();
            check($sformatf("vec_b[%0d] {tick,count,tc}", i),
                  {26'(0), tick_seen, ifb.count, ifb.tc},
                  {26'(0), vb[i].e_tick, vb[i].e_cnt, vb[i].e_tc});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
